// File: rtl/uart_peripheral.sv
// uart_peripheral: memory-mapped 8N1 UART (TXD/RXD/CON) with level interrupt.
// Optional 4-entry RX FIFO enabled by defining UART_RX_FIFO_EN.
module uart_peripheral #(
    parameter int          CLKS_PER_BIT = 10417,
    parameter logic [31:0] BASE_ADDR    = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    input  logic        MemRd,
    input  logic        MemWr,
    output logic [31:0] ReadData,
    input  logic        rx,
    output logic        tx,
    output logic        irqout
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    logic w_sel_txd, w_sel_rxd, w_sel_con, w_rd_rxd, w_rd_con, w_wr_con, w_tx_start;
    logic w_tx_busy, w_tx_tick, w_tx_end, w_rx_half, w_rx_tick, w_rx_fall, w_rx_clr;
    logic w_rx_done, w_rx_good, w_rx_bad, w_rx_valid, w_ovr, w_unused;
    logic [7:0] w_rx_byte;
    logic [31:0] w_con;
    state_t r_tx_state, w_tx_next, r_rx_state, w_rx_next;
    logic [CW-1:0] r_tx_cnt, r_rx_cnt;
    logic [2:0] r_tx_bit, r_rx_bit;
    logic [7:0] r_tx_shift, r_txd, r_rx_shift;
    logic [1:0] r_ie;
    logic r_tx, r_tx_done, r_ferr, r_ovr, r_irq, r_rx_s1, r_rx_s2, r_rx_d;
    assign w_sel_txd  = Addr == BASE_ADDR;
    assign w_sel_rxd  = Addr == BASE_ADDR + 32'd4;
    assign w_sel_con  = Addr == BASE_ADDR + 32'd8;
    assign w_rd_rxd   = MemRd & w_sel_rxd;
    assign w_rd_con   = MemRd & w_sel_con;
    assign w_wr_con   = MemWr & w_sel_con;
    assign w_tx_busy  = r_tx_state != IDLE;
    assign w_tx_start = MemWr & w_sel_txd & ~w_tx_busy;
    assign w_tx_tick  = r_tx_cnt == FULL;
    assign w_tx_end   = (r_tx_state == STOP) & w_tx_tick;
    assign w_unused   = ^WriteData[31:8];
    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            IDLE:    w_tx_next = w_tx_start ? START : IDLE;
            START:   w_tx_next = w_tx_tick ? DATA : START;
            DATA:    w_tx_next = (w_tx_tick && r_tx_bit == 3'd7) ? STOP : DATA;
            STOP:    w_tx_next = w_tx_tick ? IDLE : STOP;
            default: w_tx_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_cnt   <= (r_tx_state == IDLE || w_tx_tick) ? '0 : r_tx_cnt + 1'b1;
            if (w_tx_start) begin
                r_txd      <= WriteData[7:0];
                r_tx_shift <= WriteData[7:0];
                r_tx_bit   <= '0;
                r_tx       <= 1'b0;
            end else if (w_tx_tick && r_tx_state == START) begin
                r_tx <= r_tx_shift[0];
            end else if (w_tx_tick && r_tx_state == DATA) begin
                r_tx_shift <= r_tx_shift >> 1;
                r_tx_bit   <= r_tx_bit + 1'b1;
                r_tx       <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_shift[1];
            end
        end
    end
    // RX samples the synchronised line at mid-bit; START is timed from the detected edge
    assign w_rx_half = r_rx_cnt == HALF;
    assign w_rx_tick = r_rx_cnt == FULL;
    assign w_rx_fall = r_rx_d & ~r_rx_s2;
    assign w_rx_clr  = (r_rx_state == IDLE) | ((r_rx_state == START) ? w_rx_half : w_rx_tick);
    assign w_rx_done = (r_rx_state == STOP) & w_rx_tick;
    assign w_rx_good = w_rx_done & r_rx_s2;
    assign w_rx_bad  = w_rx_done & ~r_rx_s2;
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            IDLE:    w_rx_next = w_rx_fall ? START : IDLE;
            START:   w_rx_next = w_rx_half ? (r_rx_s2 ? IDLE : DATA) : START;
            DATA:    w_rx_next = (w_rx_tick && r_rx_bit == 3'd7) ? STOP : DATA;
            STOP:    w_rx_next = w_rx_tick ? IDLE : STOP;
            default: w_rx_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_d     <= 1'b1;
            r_rx_state <= IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1    <= rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_d     <= r_rx_s2;
            r_rx_state <= w_rx_next;
            r_rx_cnt   <= w_rx_clr ? '0 : r_rx_cnt + 1'b1;
            if (r_rx_state == IDLE) r_rx_bit <= '0;
            if (r_rx_state == DATA && w_rx_tick) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 1'b1;
            end
        end
    end
`ifdef UART_RX_FIFO_EN
    logic [7:0] r_fifo [4];
    logic [1:0] r_wp, r_rp;
    logic [2:0] r_cnt;
    logic w_pop, w_push;
    assign w_rx_valid = r_cnt != 3'd0;
    assign w_pop      = w_rd_rxd & w_rx_valid;
    assign w_push     = w_rx_good & (~r_cnt[2] | w_pop);
    assign w_ovr      = w_rx_good & r_cnt[2] & ~w_pop;
    assign w_rx_byte  = w_rx_valid ? r_fifo[r_rp] : 8'h00;
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wp] <= r_rx_shift;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= r_wp + {1'b0, w_push};
            r_rp  <= r_rp + {1'b0, w_pop};
            r_cnt <= r_cnt + {2'b0, w_push} - {2'b0, w_pop};
        end
    end
`else
    logic [7:0] r_rx_data;
    logic r_rx_valid;
    assign w_rx_valid = r_rx_valid;
    assign w_rx_byte  = r_rx_data;
    assign w_ovr      = w_rx_good & r_rx_valid & ~w_rd_rxd;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            if (w_rx_good) r_rx_data <= r_rx_shift;
            r_rx_valid <= w_rx_good | (r_rx_valid & ~w_rd_rxd);
        end
    end
`endif
    // Flag sets are ORed after the read-clear so a same-edge set wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_done <= 1'b0;
            r_ferr    <= 1'b0;
            r_ovr     <= 1'b0;
            r_ie      <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_tx_done <= w_tx_end | (r_tx_done & ~w_rd_con);
            r_ferr    <= w_rx_bad | (r_ferr & ~w_rd_con);
            r_ovr     <= w_ovr | (r_ovr & ~w_rd_con);
            if (w_wr_con) r_ie <= WriteData[1:0];
            r_irq     <= (r_ie[0] & r_tx_done) | (r_ie[1] & w_rx_valid);
        end
    end
    assign w_con    = {25'b0, r_ovr, r_ferr, w_tx_busy, w_rx_valid, r_tx_done, r_ie};
    assign ReadData = !MemRd ? '0 : w_sel_txd ? {24'b0, r_txd} : w_sel_rxd ? {24'b0, w_rx_byte} : w_sel_con ? w_con : '0;
    assign tx       = r_tx;
    assign irqout   = r_irq;
endmodule
